// File: rtl/gradient_window_sched_pkg.sv
// Shared constants, window order and FSM encodings for the gradient window sequencer.
// The gradient unit's G0..G3 window order must match WIN_TL..WIN_BR.
package gradient_window_sched_pkg;

  localparam int unsigned IMG_W   = 8;
  localparam int unsigned IMG_H   = 8;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TIMER_W = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CNT_W-1:0] FLUSH_CNT = 4'd15;
  localparam logic [CNT_W-1:0] LAST_K    = 4'd8;

  typedef enum logic [1:0] {
    WIN_TL = 2'd0,
    WIN_TR = 2'd1,
    WIN_BL = 2'd2,
    WIN_BR = 2'd3
  } win_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              pad;
  } win_addr_t;

  // Kernel row (k/3) for k = 0..8.
  function automatic logic [1:0] k_row(input logic [CNT_W-1:0] k);
    if (k < 4'd3)      return 2'd0;
    else if (k < 4'd6) return 2'd1;
    else               return 2'd2;
  endfunction

  // Kernel column (k%3) for k = 0..8.
  function automatic logic [1:0] k_col(input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] rem;
    rem = k - CNT_W'(3 * k_row(k));
    return rem[1:0];
  endfunction

endpackage

// File: rtl/gradient_window_sched_win_addr_gen.sv
// Maps (origin, window, kernel index, base) to an SRAM address and a zero-pad flag.
module gradient_window_sched_win_addr_gen
  import gradient_window_sched_pkg::*;
(
  input  logic [2:0]        org_row,
  input  logic [2:0]        org_col,
  input  win_e              win,
  input  logic [CNT_W-1:0]  k,
  input  logic [ADDR_W-1:0] base,
  output win_addr_t         res
);

  // Coordinates are carried offset by +1 so the -1 neighbour stays non-negative.
  logic [4:0]        row_p1;
  logic [4:0]        col_p1;
  logic [ADDR_W-1:0] offset;

  always_comb begin
    row_p1 = 5'(org_row) + 5'(win[1]) + 5'(k_row(k));
    col_p1 = 5'(org_col) + 5'(win[0]) + 5'(k_col(k));
    offset = ADDR_W'(row_p1) * ADDR_W'(IMG_W) + ADDR_W'(col_p1) - ADDR_W'(IMG_W + 1);
    res.addr = base + offset;
    res.pad  = (row_p1 == 5'd0) || (row_p1 > 5'(IMG_H)) ||
               (col_p1 == 5'd0) || (col_p1 > 5'(IMG_W));
  end

endmodule

// File: rtl/gradient_window_sched.sv
// Sequencer streaming four zero-padded 3x3 windows (TL,TR,BL,BR) of a 2x2 block
// from image SRAM to the gradient unit, then a flush beat, then waiting for finish.
module gradient_window_sched
  import gradient_window_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        org_row,
  input  logic [2:0]        org_col,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grad_filter_valid,
  output logic [CNT_W-1:0]  grad_i_count,
  output logic [DATA_W-1:0] grad_i_data,
  input  logic              grad_finish
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        row_q, col_q;
  win_e              iss_w_q;
  logic [CNT_W-1:0]  iss_k_q;
  logic              iss_act_q, iss_pad_q;
  logic              dlv_act_q, dlv_pad_q;
  logic [TIMER_W-1:0] timer_q;

  win_e              nxt_w;
  logic [CNT_W-1:0]  nxt_k;
  logic              nxt_flush;
  logic [ADDR_W-1:0] gen_base;
  logic [2:0]        gen_row, gen_col;
  win_addr_t         gen_res;
  logic              accept;

  gradient_window_sched_win_addr_gen u_addr_gen (
    .org_row (gen_row),
    .org_col (gen_col),
    .win     (nxt_w),
    .k       (nxt_k),
    .base    (gen_base),
    .res     (gen_res)
  );

  assign accept = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and the next issue beat (window/kernel index) to present.
  always_comb begin
    state_d   = state_q;
    nxt_w     = WIN_TL;
    nxt_k     = '0;
    nxt_flush = 1'b0;
    gen_base  = base_q;
    gen_row   = row_q;
    gen_col   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          gen_base = base_addr;
          gen_row  = org_row;
          gen_col  = org_col;
        end
      end
      ST_FETCH: begin
        if (iss_k_q == FLUSH_CNT) begin
          state_d = ST_WAIT;
        end else if ((iss_w_q == WIN_BR) && (iss_k_q == LAST_K)) begin
          nxt_w     = iss_w_q;
          nxt_k     = FLUSH_CNT;
          nxt_flush = 1'b1;
        end else if (iss_k_q == LAST_K) begin
          nxt_w = win_e'(iss_w_q + 2'd1);
        end else begin
          nxt_w = iss_w_q;
          nxt_k = iss_k_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (grad_finish || (timer_q == TIMER_W'(TIMEOUT))) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue stage, delivery stage, timer and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q            <= '0;
      row_q             <= '0;
      col_q             <= '0;
      iss_w_q           <= WIN_TL;
      iss_k_q           <= '0;
      iss_act_q         <= 1'b0;
      iss_pad_q         <= 1'b0;
      dlv_act_q         <= 1'b0;
      dlv_pad_q         <= 1'b0;
      timer_q           <= '0;
      mem_rd_en         <= 1'b0;
      mem_addr          <= '0;
      grad_filter_valid <= 1'b0;
      grad_i_count      <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= base_addr;
        row_q  <= org_row;
        col_q  <= org_col;
      end
      iss_act_q <= (state_d == ST_FETCH);
      iss_w_q   <= nxt_w;
      iss_k_q   <= nxt_k;
      iss_pad_q <= nxt_flush || gen_res.pad;
      mem_rd_en <= (state_d == ST_FETCH) && !nxt_flush && !gen_res.pad;
      if ((state_d == ST_FETCH) && !nxt_flush && !gen_res.pad) mem_addr <= gen_res.addr;

      dlv_act_q         <= iss_act_q;
      dlv_pad_q         <= iss_pad_q;
      grad_i_count      <= iss_act_q ? iss_k_q : '0;
      grad_filter_valid <= iss_act_q && ((iss_k_q == '0) || (iss_k_q == FLUSH_CNT));

      timer_q <= (state_q == ST_WAIT) ? timer_q + TIMER_W'(1) : '0;
      busy    <= (state_d == ST_FETCH) || (state_d == ST_WAIT);
      done    <= (state_d == ST_DONE);
      if (accept) err_timeout <= 1'b0;
      else if ((state_q == ST_WAIT) && (state_d == ST_DONE) && !grad_finish) err_timeout <= 1'b1;
    end
  end

  // SRAM data arrives the cycle after issue; padded and flush beats deliver zero.
  assign grad_i_data = (dlv_act_q && !dlv_pad_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_gradient_window_sched.sv
// Directed bench for gradient_window_sched with a per-cycle behavioural model and SRAM model.
module tb_gradient_window_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [2:0]  org_row, org_col;
  logic        busy, done, err_timeout, mem_rd_en;
  logic [8:0]  mem_addr;
  logic [13:0] mem_rdata = '0;
  logic        grad_filter_valid;
  logic [3:0]  grad_i_count;
  logic [13:0] grad_i_data;
  logic        grad_finish;

  int n_tests = 0;
  int n_fail  = 0;

  gradient_window_sched dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .org_row           (org_row),
    .org_col           (org_col),
    .busy              (busy),
    .done              (done),
    .err_timeout       (err_timeout),
    .mem_rd_en         (mem_rd_en),
    .mem_addr          (mem_addr),
    .mem_rdata         (mem_rdata),
    .grad_filter_valid (grad_filter_valid),
    .grad_i_count      (grad_i_count),
    .grad_i_data       (grad_i_data),
    .grad_finish       (grad_finish)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pix(input logic [8:0] a);
    return 14'(int'(a) * 3 + 5);
  endfunction

  // SRAM with one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= pix(mem_addr);

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel of beat n (0..35): window n/9, kernel n%9, around centre origin+window offset.
  function automatic void beat(input int base, input int r0, input int c0, input int n,
                               output bit pad, output int addr);
    int w, k, r, c;
    w = n / 9;
    k = n % 9;
    r = r0 + w / 2 - 1 + k / 3;
    c = c0 + w % 2 - 1 + k % 3;
    pad = (r < 0) || (r >= 8) || (c < 0) || (c >= 8);
    addr = pad ? 0 : (base + r * 8 + c) % 512;
  endfunction

  bit m_act = 0, m_toerr = 0, m_err = 0;
  int m_rel = 0, m_done = 0, m_base = 0, m_r = 0, m_c = 0, m_last = 0;

  // Model step and full output comparison every cycle.
  always @(negedge clk) begin
    bit e_rd, e_busy, e_done, e_valid, pad;
    int e_cnt, e_data, a, n;
    e_rd = 0; e_busy = 0; e_done = 0; e_valid = 0; e_cnt = 0; e_data = 0; pad = 0; a = 0; n = 0;
    if (!rst_n) begin
      m_act = 0; m_err = 0; m_last = 0;
    end else if (m_act) begin
      if (m_rel == 1) m_err = 0;
      if (m_rel >= 1 && m_rel <= 36) begin
        beat(m_base, m_r, m_c, m_rel - 1, pad, a);
        if (!pad) begin e_rd = 1; m_last = a; end
      end
      if (m_rel >= 2 && m_rel <= 38) begin
        n = m_rel - 2;
        e_valid = (n % 9 == 0) || (n == 36);
        e_cnt   = (n == 36) ? 15 : n % 9;
        if (n < 36) begin
          beat(m_base, m_r, m_c, n, pad, a);
          e_data = pad ? 0 : int'(pix(9'(a)));
        end
      end
      e_busy = (m_done == 0) || (m_rel < m_done);
      if (m_rel == m_done) begin e_done = 1; m_err = m_toerr; end
    end
    chk("mem_rd_en", mem_rd_en, e_rd);
    chk("mem_addr", mem_addr, m_last);
    chk("grad_filter_valid", grad_filter_valid, e_valid);
    chk("grad_i_count", grad_i_count, e_cnt);
    chk("grad_i_data", grad_i_data, e_data);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("err_timeout", err_timeout, m_err);
    if (rst_n) begin
      if (m_act) begin
        if (m_rel >= 38 && m_done == 0) begin
          if (grad_finish) m_done = m_rel + 1;
          else if (m_rel == 54) begin m_done = 55; m_toerr = 1; end
        end
        if (m_rel == m_done) m_act = 0;
        else m_rel++;
      end else if (start) begin
        m_act = 1; m_rel = 1; m_done = 0; m_toerr = 0;
        m_base = base_addr; m_r = org_row; m_c = org_col;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns positioned in the first issue cycle.
  task automatic go(input int b, input int r, input int c);
    base_addr = 9'(b);
    org_row   = 3'(r);
    org_col   = 3'(c);
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; grad_finish = 1'b0;
    base_addr = '0; org_row = '0; org_col = '0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step(2);

    // base 64, origin (2,4): first read at 64+1*8+3, finish 4 cycles into WAIT
    go(64, 2, 4);
    chk("t1_addr", mem_addr, 75);
    chk("t1_rd_en", mem_rd_en, 1);
    step(1);
    chk("t1_valid", grad_filter_valid, 1);
    chk("t1_count", grad_i_count, 0);
    chk("t1_data", grad_i_data, 230);
    step(40);
    grad_finish = 1'b1;
    step(1);
    grad_finish = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_err", err_timeout, 0);
    step(2);

    // origin (0,0): TL top-left corner padded; grad_finish during FETCH ignored
    go(0, 0, 0);
    chk("t2_k0_rd_en", mem_rd_en, 0);
    step(4);
    chk("t2_k4_rd_en", mem_rd_en, 1);
    chk("t2_k4_addr", mem_addr, 0);
    step(4);
    grad_finish = 1'b1;
    step(1);
    grad_finish = 1'b0;
    chk("t2_busy_fetch", busy, 1);
    step(28);
    grad_finish = 1'b1;
    step(1);
    grad_finish = 1'b0;
    chk("t2_done", done, 1);
    step(2);

    // origin (6,6): BR edge padding, flush beat, start during FETCH/DONE ignored, timeout
    go(100, 6, 6);
    step(9);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(27);
    chk("t3_flush_count", grad_i_count, 15);
    chk("t3_flush_valid", grad_filter_valid, 1);
    chk("t3_flush_data", grad_i_data, 0);
    step(17);
    chk("t3_done", done, 1);
    chk("t3_err", err_timeout, 1);
    chk("t3_busy", busy, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("t3_start_in_done", busy, 0);
    chk("t3_err_sticky", err_timeout, 1);
    step(1);

    // new start clears the error; reset asserted mid-FETCH
    go(200, 4, 2);
    chk("t4_err_clear", err_timeout, 0);
    step(19);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_rd_en", mem_rd_en, 0);
    chk("t4_rst_addr", mem_addr, 0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // restart from k=0; grad_finish coincident with timer==TIMEOUT is a success
    go(5, 2, 2);
    chk("t5_addr", mem_addr, 14);
    step(1);
    chk("t5_count", grad_i_count, 0);
    chk("t5_valid", grad_filter_valid, 1);
    step(52);
    grad_finish = 1'b1;
    step(1);
    grad_finish = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_err", err_timeout, 0);
    step(2);

    // address wraps modulo 512
    go(500, 6, 6);
    chk("t6_wrap_addr", mem_addr, 33);
    step(37);
    grad_finish = 1'b1;
    step(1);
    grad_finish = 1'b0;
    chk("t6_done", done, 1);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
